cordic_atan2_mag: RTL and testbench

//  Vectoring-mode CORDIC: the inverse of the sin/cos rotator. Takes a signed Q2.14 (x,y)

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_atan_rom.sv | 12 +
 rtl/cordic_atan2_mag.sv | 155 +++++++++++++++
 tb/tb_cordic_atan2_mag.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Constants and types shared by the CORDIC sin/cos and atan2/magnitude blocks.
// Angles are Q14 radians, lengths Q2.14.
package cordic_pkg;

   localparam int C_ITERS = 16;
   localparam int C_DW    = 16;
   localparam int C_IW    = 18;

   localparam logic [15:0] K_INV   = 16'h26DD;
   localparam logic [15:0] RAD2DEG = 16'd917;
   localparam logic [15:0] DEG2RAD = 16'd286;

   localparam logic [15:0] ATAN_TABLE [16] = '{
      16'h3244, 16'h1DAC, 16'h0FAE, 16'h07F5,
      16'h03FF, 16'h0200, 16'h0100, 16'h0080,
      16'h0040, 16'h0020, 16'h0010, 16'h0008,
      16'h0004, 16'h0002, 16'h0001, 16'h0000
   };

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ITER,
      POST
   } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup: atan(2^-i) in Q14 radians.
// Shared by the sin/cos rotator and the vectoring block.
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [3:0]  i_idx,
   output logic [15:0] o_atan
);

   assign o_atan = ATAN_TABLE[i_idx];

endmodule

// File: rtl/cordic_atan2_mag.sv
// Vectoring-mode CORDIC: atan2(y,x) in integer degrees and
// gain-compensated magnitude, one micro-rotation per clock.
module cordic_atan2_mag
   import cordic_pkg::*;
#(
   parameter int ITERS = C_ITERS,
   parameter int DW    = C_DW,
   parameter int IW    = C_IW
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic signed [DW-1:0] i_x,
   input  logic signed [DW-1:0] i_y,
   output logic signed [DW-1:0] angle_out,
   output logic signed [DW-1:0] mag_out,
   output logic                 busy,
   output logic                 done
);

   state_t r_state;
   state_t w_state_nx;

   logic signed [DW-1:0] r_cap_x;
   logic signed [DW-1:0] r_cap_y;
   logic signed [IW-1:0] r_x;
   logic signed [IW-1:0] r_y;
   logic signed [IW-1:0] r_z;
   logic [3:0]           r_iter;
   logic                 r_neg;
   logic                 r_ysgn;
   logic                 r_zero;

   logic [15:0]          w_atan;
   logic signed [IW-1:0] w_atan_e;
   logic signed [IW-1:0] w_xe;
   logic signed [IW-1:0] w_ye;
   logic signed [IW-1:0] w_xs;
   logic signed [IW-1:0] w_ys;
   logic                 w_ypos;
   logic                 w_last;
   logic signed [31:0]   w_zprod;
   logic signed [31:0]   w_deg;
   logic signed [31:0]   w_mprod;
   logic signed [31:0]   w_mag;
   logic signed [DW-1:0] w_mag_sat;

   cordic_atan_rom u_rom (
      .i_idx  (r_iter),
      .o_atan (w_atan)
   );

   assign busy     = (r_state != IDLE);
   assign w_last   = (r_iter == 4'(ITERS - 1));
   assign w_atan_e = IW'(w_atan);
   assign w_xe     = IW'(r_cap_x);
   assign w_ye     = IW'(r_cap_y);
   assign w_xs     = r_x >>> r_iter;
   assign w_ys     = r_y >>> r_iter;
   assign w_ypos   = ~r_y[IW-1];

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nx = LOAD;
         LOAD:    w_state_nx = ITER;
         ITER:    if (w_last) w_state_nx = POST;
         POST:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Left-half-plane inputs were mirrored in LOAD; fold the angle back here.
   always_comb begin
      w_zprod = 32'(r_z) * $signed({16'd0, RAD2DEG});
      w_deg   = (w_zprod + 32'sd131072) >>> 18;
      if (r_neg) begin
         w_deg = r_ysgn ? (w_deg - 32'sd180) : (w_deg + 32'sd180);
      end
      if (w_deg == -32'sd180) begin
         w_deg = 32'sd180;
      end
      if (r_zero) begin
         w_deg = '0;
      end
   end

   always_comb begin
      w_mprod = 32'(r_x) * $signed({16'd0, K_INV});
      w_mag   = (w_mprod + 32'sd8192) >>> 14;
      if (w_mag > 32'sd32767) begin
         w_mag_sat = 16'sh7FFF;
      end else begin
         w_mag_sat = DW'(w_mag);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cap_x   <= '0;
         r_cap_y   <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_z       <= '0;
         r_iter    <= '0;
         r_neg     <= 1'b0;
         r_ysgn    <= 1'b0;
         r_zero    <= 1'b0;
         angle_out <= '0;
         mag_out   <= '0;
         done      <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         done    <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_cap_x <= i_x;
                  r_cap_y <= i_y;
               end
            end
            LOAD: begin
               r_neg  <= r_cap_x[DW-1];
               r_ysgn <= r_cap_y[DW-1];
               r_zero <= (r_cap_x == '0) && (r_cap_y == '0);
               r_x    <= r_cap_x[DW-1] ? -w_xe : w_xe;
               r_y    <= r_cap_x[DW-1] ? -w_ye : w_ye;
               r_z    <= '0;
               r_iter <= '0;
            end
            ITER: begin
               if (w_ypos) begin
                  r_x <= r_x + w_ys;
                  r_y <= r_y - w_xs;
                  r_z <= r_z + w_atan_e;
               end else begin
                  r_x <= r_x - w_ys;
                  r_y <= r_y + w_xs;
                  r_z <= r_z - w_atan_e;
               end
               r_iter <= r_iter + 4'd1;
            end
            POST: begin
               angle_out <= DW'(w_deg);
               mag_out   <= w_mag_sat;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// Bench for cordic_atan2_mag: directed corners plus a random sweep
// against a real-valued atan2 / hypot reference.
module tb_cordic_atan2_mag;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic signed [15:0] i_x;
   logic signed [15:0] i_y;
   logic signed [15:0] angle_out;
   logic signed [15:0] mag_out;
   logic               busy;
   logic               done;

   int n_vec = 0;
   int n_err = 0;

   localparam real PI = 3.14159265358979;

   always #5 clk = ~clk;

   cordic_atan2_mag dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .i_x       (i_x),
      .i_y       (i_y),
      .angle_out (angle_out),
      .mag_out   (mag_out),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input longint got,
                      input longint exp, input longint tol);
      n_vec++;
      if (got > exp + tol || got < exp - tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                  tag, got, exp, tol);
      end
   endtask

   function automatic int ref_angle(input int x, input int y);
      real a;
      int  d;
      a = $atan2(real'(y), real'(x)) * 180.0 / PI;
      d = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
      if (d <= -180) d += 360;
      return d;
   endfunction

   function automatic int ref_mag(input int x, input int y);
      real m;
      m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      if (m >= 32767.0) return 32767;
      return $rtoi(m + 0.5);
   endfunction

   function automatic int wrap_to(input int got, input int exp);
      int e;
      e = exp;
      if (got - e > 180) e += 360;
      if (got - e < -180) e -= 360;
      return e;
   endfunction

   task automatic run_op(input logic signed [15:0] x,
                         input logic signed [15:0] y,
                         output int lat, output logic b0);
      @(negedge clk);
      i_x   = x;
      i_y   = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      b0    = busy;
      lat   = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic dir(input string tag, input int x, input int y,
                      input int exp_ang, input int exp_mag, input int mtol);
      int   lat;
      logic b0;
      run_op(16'(x), 16'(y), lat, b0);
      chk({tag, "_lat"}, lat, 18, 0);
      chk({tag, "_ang"}, angle_out, exp_ang, 0);
      chk({tag, "_mag"}, mag_out, exp_mag, mtol);
   endtask

   initial begin
      int   lat;
      int   ndone;
      int   first_ang;
      int   first_lat;
      logic b0;
      logic signed [15:0] rx;
      logic signed [15:0] ry;
      int   ea;

      reset = 1'b1;
      start = 1'b0;
      i_x   = '0;
      i_y   = '0;
      #12;
      chk("rst_ang", angle_out, 0, 0);
      chk("rst_mag", mag_out, 0, 0);
      chk("rst_busy", busy, 0, 0);
      chk("rst_done", done, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op(16'sd16384, 16'sd0, lat, b0);
      chk("t1_busy", b0, 1, 0);
      chk("t1_lat", lat, 18, 0);
      chk("t1_ang", angle_out, 0, 0);
      chk("t1_mag", mag_out, 16384, 8);
      chk("t1_busy_at_done", busy, 0, 0);
      @(posedge clk);
      #1;
      chk("t1_done_width", done, 0, 0);
      chk("t1_hold_ang", angle_out, 0, 0);

      dir("t2_p90", 0, 16384, 90, 16384, 8);
      dir("t2_m90", 0, -16384, -90, 16384, 8);
      dir("t2_45", 11585, 11585, 45, 16384, 8);
      dir("t3_180", -16384, 0, 180, 16384, 8);
      dir("t3_180b", -16384, -1, 180, 16384, 8);
      dir("t3_m135", -11585, -11585, -135, 16384, 8);
      dir("t4_sat", -32768, -32768, -135, 32767, 0);
      dir("t4_zero", 0, 0, 0, 0, 0);

      // Extra starts while busy must be dropped.
      @(negedge clk);
      i_x   = 16'sd16384;
      i_y   = 16'sd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      i_x       = 16'sd0;
      i_y       = 16'sd16384;
      ndone     = 0;
      first_ang = 999;
      first_lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_ang = angle_out;
               first_lat = k;
            end
         end
         start = (k == 2) || (k == 9);
      end
      chk("t5_ndone", ndone, 1, 0);
      chk("t5_lat", first_lat, 18, 0);
      chk("t5_ang", first_ang, 0, 0);

      dir("t6_pre", 11585, 11585, 45, 16384, 8);
      @(negedge clk);
      i_x   = 16'sd0;
      i_y   = -16'sd16384;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_ang", angle_out, 0, 0);
      chk("t6_mag", mag_out, 0, 0);
      chk("t6_busy", busy, 0, 0);
      chk("t6_done", done, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      dir("t6_post", 0, 16384, 90, 16384, 8);

      for (int n = 0; n < 2000; n++) begin
         do begin
            rx = 16'($urandom);
            ry = 16'($urandom);
         end while (ref_mag(rx, ry) < 4096);
         run_op(rx, ry, lat, b0);
         chk("rnd_lat", lat, 18, 0);
         ea = wrap_to(angle_out, ref_angle(rx, ry));
         chk($sformatf("rnd_ang(%0d,%0d)", rx, ry), angle_out, ea, 1);
         chk($sformatf("rnd_mag(%0d,%0d)", rx, ry), mag_out,
             ref_mag(rx, ry), 8);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
